uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among NREQ byte-stream requesters, such as the console teleprinter, the debug monitor and the loader echo.
- Arbitration is message-level round-robin. A granted requester keeps the transmitter until it sends a byte flagged last, or until it idles longer than TIMEOUT cycles.
- Drives the UART's load/data/ready interface. Sits between the requesters and the UART TX instance in the top level.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BUSY = 2'd2
  } state_t;

  localparam int unsigned BYTE_W    = 8;
  // Cycles after a load during which uart_ready is not trusted.
  localparam int unsigned GUARD_CYC = 2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned GID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [GID_W-1:0] ptr,
  output logic             any,
  output logic [GID_W-1:0] winner
);

  logic [2*NREQ-1:0] masked;

  // Lower copy masked below ptr, upper copy unmasked: the lowest set bit of the
  // double-width vector is the wrapped round-robin winner.
  always_comb begin
    masked = {req, req};
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i < 32'(ptr)) masked[i] = 1'b0;
    end
    any    = |req;
    winner = '0;
    for (int unsigned j = 2 * NREQ; j > 0; j--) begin
      if (masked[j-1]) begin
        winner = (j - 1 >= NREQ) ? GID_W'(j - 1 - NREQ) : GID_W'(j - 1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one UART transmitter among NREQ
// byte-stream requesters, with an idle timeout on the granted requester.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned GID_W   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [8*NREQ-1:0]      req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   uart_load,
  output logic [7:0]             uart_data,
  input  logic                   uart_ready,
  output logic [GID_W-1:0]       grant_id,
  output logic                   busy,
  output logic                   timeout_evt
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GRD_W = $clog2(GUARD_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [GID_W-1:0]    grant_q, grant_d;
  logic [GID_W-1:0]    ptr_q, ptr_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GRD_W-1:0]    guard_q, guard_d;
  logic                last_q, last_d;
  logic                load_q, load_d;
  logic                tout_q, tout_d;
  logic                busy_q, busy_d;
  logic [BYTE_W-1:0]   data_q, data_d;

  logic                pick_any;
  logic [GID_W-1:0]    pick_w;
  logic                own_valid;
  logic                own_last;
  logic [BYTE_W-1:0]   own_data;
  logic [GID_W-1:0]    ptr_next;

  rr_pick #(
    .NREQ  (NREQ),
    .GID_W (GID_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_w)
  );

  // Owner-side view of the request bus and the pointer just past the owner.
  always_comb begin
    own_valid = req_valid[grant_q];
    own_last  = req_last[grant_q];
    own_data  = req_data[32'(grant_q) * BYTE_W +: BYTE_W];
    ptr_next  = (grant_q == GID_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
  end

  // Accept strobe goes only to the owner, only in SEND, gated by UART idle.
  always_comb begin
    req_ready = '0;
    if (state_q == SEND) req_ready[grant_q] = uart_ready;
  end

  // Arbitration FSM, gap/guard counters and output register next-state.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    guard_d = guard_q;
    last_d  = last_q;
    data_d  = data_q;
    load_d  = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_w;
          gap_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (uart_ready) begin
          // An accept on the terminal-count cycle takes priority over timeout.
          if (own_valid) begin
            data_d  = own_data;
            last_d  = own_last;
            gap_d   = '0;
            guard_d = '0;
            load_d  = 1'b1;
            state_d = BUSY;
          end else if (gap_q >= GAP_TC) begin
            gap_d   = GAP_W'(TIMEOUT);
            tout_d  = 1'b1;
            ptr_d   = ptr_next;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      BUSY: begin
        if (guard_q < GRD_W'(GUARD_CYC)) begin
          guard_d = guard_q + 1'b1;
        end else if (uart_ready) begin
          if (last_q) begin
            ptr_d   = ptr_next;
            state_d = IDLE;
          end else begin
            gap_d   = '0;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      guard_q <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      load_q  <= 1'b0;
      tout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      guard_q <= guard_d;
      last_q  <= last_d;
      data_q  <= data_d;
      load_q  <= load_d;
      tout_q  <= tout_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_load   = load_q;
  assign uart_data   = data_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_evt = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple UART TX busy model.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned GID_W   = 2;
  localparam int          FRAME   = 12 * 5;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic [NREQ-1:0]      req_valid;
  logic [8*NREQ-1:0]    req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 uart_load;
  logic [7:0]           uart_data;
  logic                 uart_ready;
  logic [GID_W-1:0]     grant_id;
  logic                 busy;
  logic                 timeout_evt;

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .uart_load   (uart_load),
    .uart_data   (uart_data),
    .uart_ready  (uart_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-requester pending bytes {last, data}; expected loads {gid, data}.
  logic [8:0]  rq [NREQ][$];
  logic [15:0] sb [$];

  int   cyc       = 0;
  int   rise_edge = -1000;
  int   n_tout    = 0;
  int   busy_cnt  = 0;
  logic run       = 1'b0;

  task automatic present();
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        e = rq[i][0];
        req_valid[i]         = 1'b1;
        req_data[i*8 +: 8]   = e[7:0];
        req_last[i]          = e[8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*8 +: 8]   = 8'h00;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  // Pushes are issued in the order the arbiter is expected to send them.
  task automatic push(input int id, input logic [7:0] d, input logic last);
    rq[id].push_back({last, d});
    sb.push_back({8'(id), d});
    present();
  endtask

  // Per-cycle monitor, UART model and requester handshake.
  initial begin
    logic [NREQ-1:0] s_acc;
    logic            s_load, s_rdy, s_tout;
    logic [7:0]      s_data;
    logic [GID_W-1:0] s_gid;
    logic            prev_rdy, prev_load, prev_tout;
    logic [15:0]     e;
    prev_rdy = 1'b1; prev_load = 1'b0; prev_tout = 1'b0;
    forever begin
      @(negedge clk);
      s_acc  = req_valid & req_ready;
      s_load = uart_load;
      s_data = uart_data;
      s_gid  = grant_id;
      s_rdy  = uart_ready;
      s_tout = timeout_evt;
      if (run && nrst) begin
        if (s_rdy && !prev_rdy) rise_edge = cyc + 1;
        if (s_load) begin
          chk("load_while_uart_busy", 32'(busy_cnt != 0), 0);
          chk("load_back_to_back", 32'(prev_load), 0);
          if (sb.size() == 0) chk("unexpected_load", 1, 0);
          else begin
            e = sb.pop_front();
            chk("uart_data", 32'(s_data), 32'(e[7:0]));
            chk("load_grant_id", 32'(s_gid), 32'(e[15:8]));
          end
        end
        if (s_tout) begin
          n_tout++;
          chk("timeout_distance", 32'(cyc - rise_edge), TIMEOUT);
          chk("timeout_single_pulse", 32'(prev_tout), 0);
        end
        if ($countones(s_acc) > 1) chk("ready_onehot", 32'(s_acc), 0);
      end
      prev_rdy  = s_rdy;
      prev_load = s_load;
      prev_tout = s_tout;
      @(posedge clk);
      cyc++;
      #1;
      if (!nrst) busy_cnt = 0;
      else if (s_load) busy_cnt = FRAME;
      else if (busy_cnt > 0) busy_cnt--;
      uart_ready = (busy_cnt == 0);
      if (nrst) begin
        for (int i = 0; i < NREQ; i++) begin
          if (s_acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
      end
      present();
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    nrst = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    sb.delete();
    busy_cnt   = 0;
    uart_ready = 1'b1;
    present();
    #1;
    chk("rst_uart_load", 32'(uart_load), 0);
    chk("rst_uart_data", 32'(uart_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout_evt", 32'(timeout_evt), 0);
    repeat (2) @(posedge clk);
    #2;
    nrst = 1'b1;
  endtask

  function automatic bit all_empty();
    bit r = (sb.size() == 0);
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk);
      #2;
      if (all_empty() && !busy && uart_ready) break;
    end
    if (k == 3000) chk(tag, 0, 1);
  endtask

  initial begin
    int t0, k, mark;
    nrst       = 1'b1;
    uart_ready = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    #2;
    nrst = 1'b0;
    #1;
    chk("init_uart_load", 32'(uart_load), 0);
    chk("init_uart_data", 32'(uart_data), 0);
    chk("init_grant_id", 32'(grant_id), 0);
    chk("init_busy", 32'(busy), 0);
    chk("init_timeout_evt", 32'(timeout_evt), 0);
    chk("init_req_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #2;
    nrst = 1'b1;
    run  = 1'b1;

    // Single requester "Hi"; then 2 and 1 together prove ptr moved to 2.
    push(1, 8'h48, 1'b0);
    push(1, 8'h69, 1'b1);
    wait_done("drain_single");
    push(2, 8'hA1, 1'b1);
    push(1, 8'hB1, 1'b1);
    wait_done("drain_ptr_after_single");

    // Contention: 0, 2, 3 with 3-byte messages.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      if (r != 1) begin
        for (int b = 0; b < 3; b++) push(r, 8'(16 * r + b), b == 2);
      end
    end
    wait_done("drain_contention");

    // Rotation fairness between 0 and 1 with 1-byte messages.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      push(0, 8'(8'hC0 + b), 1'b1);
      push(1, 8'(8'hD0 + b), 1'b1);
    end
    wait_done("drain_rotation");

    // Timeout: requester 2 stalls mid-message, requester 0 waits.
    do_reset();
    t0 = n_tout;
    push(2, 8'h2A, 1'b0);
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      #2;
      if (busy && grant_id == 2'd2) break;
    end
    if (k == 200) chk("wait_grant2", 0, 1);
    push(0, 8'h0B, 1'b1);
    wait_done("drain_timeout");
    chk("timeout_count", 32'(n_tout - t0), 1);
    chk("post_timeout_grant", 32'(grant_id), 0);

    // Reset while BUSY abandons the message; arbitration restarts at 0.
    do_reset();
    push(3, 8'h31, 1'b0);
    push(3, 8'h32, 1'b1);
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 1) break;
    end
    if (k == 200) chk("wait_first_load", 0, 1);
    repeat (5) @(posedge clk);
    #2;
    chk("busy_before_reset", 32'(busy), 1);
    do_reset();
    push(0, 8'h01, 1'b1);
    push(3, 8'h33, 1'b1);
    wait_done("drain_after_reset");

    // Accept on the terminal-count cycle wins over timeout.
    do_reset();
    t0 = n_tout;
    mark = cyc;
    push(2, 8'h5A, 1'b0);
    for (k = 0; k < 500; k++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && rise_edge > mark + 5) break;
    end
    if (k == 500) chk("wait_uart_ready", 0, 1);
    for (k = 0; k < 100 && cyc < rise_edge + int'(TIMEOUT) - 1; k++) begin
      @(posedge clk);
      #2;
    end
    push(2, 8'h5B, 1'b1);
    wait_done("drain_race");
    chk("race_no_timeout", 32'(n_tout - t0), 0);

    chk("scoreboard_left", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
